// File: rtl/snax_csr_req_buffer.sv
// CSR request/response decoupling buffer between the SNAX translator and the streamer.
// In-order request and response FIFOs; reads are admitted only against free response credits.
module snax_csr_req_buffer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned ReqDepth  = 4,
  parameter int unsigned RspDepth  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [DataWidth-1:0]            up_req_data_i,
  input  logic [AddrWidth-1:0]            up_req_addr_i,
  input  logic                            up_req_write_i,
  input  logic                            up_req_valid_i,
  output logic                            up_req_ready_o,
  output logic [DataWidth-1:0]            up_rsp_data_o,
  output logic                            up_rsp_valid_o,
  input  logic                            up_rsp_ready_i,
  output logic [DataWidth-1:0]            dn_req_data_o,
  output logic [AddrWidth-1:0]            dn_req_addr_o,
  output logic                            dn_req_write_o,
  output logic                            dn_req_valid_o,
  input  logic                            dn_req_ready_i,
  input  logic [DataWidth-1:0]            dn_rsp_data_i,
  input  logic                            dn_rsp_valid_i,
  output logic                            dn_rsp_ready_o,
  output logic [$clog2(RspDepth+1)-1:0]   rd_outstanding_o,
  output logic                            idle_o,
  output logic                            err_o
);

  localparam int unsigned ReqPtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int unsigned RspPtrW = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned ReqCntW = $clog2(ReqDepth + 1);
  localparam int unsigned RspCntW = $clog2(RspDepth + 1);

  localparam logic [ReqCntW-1:0] ReqFull = ReqCntW'(ReqDepth);
  localparam logic [RspCntW-1:0] RspFull = RspCntW'(RspDepth);
  localparam logic [ReqPtrW-1:0] ReqLast = ReqPtrW'(ReqDepth - 1);
  localparam logic [RspPtrW-1:0] RspLast = RspPtrW'(RspDepth - 1);

  function automatic logic [ReqPtrW-1:0] req_ptr_next(input logic [ReqPtrW-1:0] p);
    return (p == ReqLast) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RspPtrW-1:0] rsp_ptr_next(input logic [RspPtrW-1:0] p);
    return (p == RspLast) ? '0 : p + 1'b1;
  endfunction

  logic [DataWidth-1:0] req_data_q  [ReqDepth];
  logic [AddrWidth-1:0] req_addr_q  [ReqDepth];
  logic                 req_write_q [ReqDepth];
  logic [ReqPtrW-1:0]   req_wptr_q, req_rptr_q;
  logic [ReqCntW-1:0]   req_cnt_q;

  logic [DataWidth-1:0] rsp_data_q [RspDepth];
  logic [RspPtrW-1:0]   rsp_wptr_q, rsp_rptr_q;
  logic [RspCntW-1:0]   rsp_cnt_q;

  logic [RspCntW-1:0]   rd_out_q;
  logic                 err_q;

  logic req_push, req_pop, rsp_push, rsp_pop, rd_inc;

  // Ready looks only at registered occupancy/credits; a same-cycle pop never frees a slot early.
  assign up_req_ready_o = (req_cnt_q < ReqFull) & (up_req_write_i | (rd_out_q < RspFull));
  assign req_push       = up_req_valid_i & up_req_ready_o;
  assign dn_req_valid_o = (req_cnt_q != '0);
  assign req_pop        = dn_req_valid_o & dn_req_ready_i;
  assign dn_req_data_o  = req_data_q[req_rptr_q];
  assign dn_req_addr_o  = req_addr_q[req_rptr_q];
  assign dn_req_write_o = req_write_q[req_rptr_q];

  assign dn_rsp_ready_o = (rsp_cnt_q != RspFull);
  assign rsp_push       = dn_rsp_valid_i & dn_rsp_ready_o;
  assign up_rsp_valid_o = (rsp_cnt_q != '0);
  assign rsp_pop        = up_rsp_valid_o & up_rsp_ready_i;
  assign up_rsp_data_o  = rsp_data_q[rsp_rptr_q];

  assign rd_inc           = req_push & ~up_req_write_i;
  assign rd_outstanding_o = rd_out_q;
  assign idle_o           = (req_cnt_q == '0) & (rd_out_q == '0);
  assign err_o            = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ReqDepth; i++) begin
        req_data_q[i]  <= '0;
        req_addr_q[i]  <= '0;
        req_write_q[i] <= 1'b0;
      end
      req_wptr_q <= '0;
      req_rptr_q <= '0;
      req_cnt_q  <= '0;
    end else begin
      if (req_push) begin
        req_data_q[req_wptr_q]  <= up_req_data_i;
        req_addr_q[req_wptr_q]  <= up_req_addr_i;
        req_write_q[req_wptr_q] <= up_req_write_i;
        req_wptr_q              <= req_ptr_next(req_wptr_q);
      end
      if (req_pop) req_rptr_q <= req_ptr_next(req_rptr_q);
      case ({req_push, req_pop})
        2'b10:   req_cnt_q <= req_cnt_q + 1'b1;
        2'b01:   req_cnt_q <= req_cnt_q - 1'b1;
        default: req_cnt_q <= req_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RspDepth; i++) rsp_data_q[i] <= '0;
      rsp_wptr_q <= '0;
      rsp_rptr_q <= '0;
      rsp_cnt_q  <= '0;
    end else begin
      if (rsp_push) begin
        rsp_data_q[rsp_wptr_q] <= dn_rsp_data_i;
        rsp_wptr_q             <= rsp_ptr_next(rsp_wptr_q);
      end
      if (rsp_pop) rsp_rptr_q <= rsp_ptr_next(rsp_rptr_q);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt_q <= rsp_cnt_q + 1'b1;
        2'b01:   rsp_cnt_q <= rsp_cnt_q - 1'b1;
        default: rsp_cnt_q <= rsp_cnt_q;
      endcase
    end
  end

  // A credit is held from read acceptance until its response leaves upstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case ({rd_inc, rsp_pop})
        2'b10:   rd_out_q <= rd_out_q + 1'b1;
        2'b01:   rd_out_q <= rd_out_q - 1'b1;
        default: rd_out_q <= rd_out_q;
      endcase
      if (dn_rsp_valid_i && !dn_rsp_ready_o) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snax_csr_req_buffer.sv
// Directed bench for snax_csr_req_buffer: reset, write burst, read credits, mixed traffic,
// overflow error, reset mid-traffic and a randomized-stall in-order scoreboard run.
module tb_snax_csr_req_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] up_req_data = '0;
  logic [31:0] up_req_addr = '0;
  logic        up_req_write = 1'b0;
  logic        up_req_valid = 1'b0;
  logic        up_req_ready;
  logic [31:0] up_rsp_data;
  logic        up_rsp_valid;
  logic        up_rsp_ready = 1'b0;
  logic [31:0] dn_req_data;
  logic [31:0] dn_req_addr;
  logic        dn_req_write;
  logic        dn_req_valid;
  logic        dn_req_ready = 1'b0;
  logic [31:0] dn_rsp_data = '0;
  logic        dn_rsp_valid = 1'b0;
  logic        dn_rsp_ready;
  logic [1:0]  rd_out;
  logic        idle;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  snax_csr_req_buffer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .up_req_data_i(up_req_data), .up_req_addr_i(up_req_addr), .up_req_write_i(up_req_write),
    .up_req_valid_i(up_req_valid), .up_req_ready_o(up_req_ready),
    .up_rsp_data_o(up_rsp_data), .up_rsp_valid_o(up_rsp_valid), .up_rsp_ready_i(up_rsp_ready),
    .dn_req_data_o(dn_req_data), .dn_req_addr_o(dn_req_addr), .dn_req_write_o(dn_req_write),
    .dn_req_valid_o(dn_req_valid), .dn_req_ready_i(dn_req_ready),
    .dn_rsp_data_i(dn_rsp_data), .dn_rsp_valid_i(dn_rsp_valid), .dn_rsp_ready_o(dn_rsp_ready),
    .rd_outstanding_o(rd_out), .idle_o(idle), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic up_drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    up_req_valid = v;
    up_req_write = w;
    up_req_addr  = a;
    up_req_data  = d;
  endtask

  int          j;
  int          u;
  logic        acc;
  logic        done;
  logic [64:0] e;
  logic [31:0] r;
  logic [64:0] exp_req[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] pend[$];

  initial begin
    // reset values
    #3;
    chk("rst_up_req_ready", up_req_ready, 1);
    chk("rst_dn_req_valid", dn_req_valid, 0);
    chk("rst_up_rsp_valid", up_rsp_valid, 0);
    chk("rst_dn_req_data", dn_req_data, 0);
    chk("rst_dn_req_addr", dn_req_addr, 0);
    chk("rst_dn_req_write", dn_req_write, 0);
    chk("rst_up_rsp_data", up_rsp_data, 0);
    chk("rst_dn_rsp_ready", dn_rsp_ready, 1);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // write burst against a stalled streamer
    j = 0;
    for (int c = 0; c < 6; c++) begin
      up_drive(1'b1, 1'b1, 32'h3C0 + 32'(j), 32'hD0 + 32'(j));
      #1;
      chk("wb_ready", up_req_ready, (c < 4) ? 1 : 0);
      if (c == 0) chk("wb_idle_before", idle, 1);
      if (c == 1) chk("wb_idle_after", idle, 0);
      acc = up_req_ready;
      step();
      if (acc) j++;
    end
    chk("wb_accepted", j, 4);
    dn_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (j < 6) up_drive(1'b1, 1'b1, 32'h3C0 + 32'(j), 32'hD0 + 32'(j));
      else up_drive(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      if (k == 0) chk("wb_full_pop_ready", up_req_ready, 0);
      chk("wb_dn_valid", dn_req_valid, 1);
      chk("wb_dn_addr", dn_req_addr, 32'h3C0 + 32'(k));
      chk("wb_dn_data", dn_req_data, 32'hD0 + 32'(k));
      chk("wb_dn_write", dn_req_write, 1);
      chk("wb_no_rsp", up_rsp_valid, 0);
      acc = up_req_valid & up_req_ready;
      step();
      if (acc) j++;
    end
    #1;
    chk("wb_drained", dn_req_valid, 0);
    chk("wb_idle_end", idle, 1);

    // read credits: third read stalls at two outstanding
    up_drive(1'b1, 1'b0, 32'h10, 32'h0);
    #1; chk("rc_r0_ready", up_req_ready, 1);
    step();
    up_drive(1'b1, 1'b0, 32'h11, 32'h0);
    #1; chk("rc_r1_ready", up_req_ready, 1);
    chk("rc_head0", dn_req_addr, 32'h10);
    chk("rc_head0_wr", dn_req_write, 0);
    step();
    up_drive(1'b1, 1'b0, 32'h12, 32'h0);
    dn_rsp_valid = 1'b1; dn_rsp_data = 32'hA;
    #1; chk("rc_r2_stall", up_req_ready, 0);
    chk("rc_out2", rd_out, 2);
    chk("rc_head1", dn_req_addr, 32'h11);
    step();
    dn_rsp_data = 32'hB;
    #1; chk("rc_r2_stall2", up_req_ready, 0);
    step();
    dn_rsp_valid = 1'b0;
    #1;
    chk("rc_rsp_valid", up_rsp_valid, 1);
    chk("rc_rsp_a", up_rsp_data, 32'hA);
    chk("rc_no_head", dn_req_valid, 0);
    up_rsp_ready = 1'b1;
    #1; chk("rc_ready_registered", up_req_ready, 0);
    step();
    #1;
    chk("rc_rsp_b", up_rsp_data, 32'hB);
    chk("rc_out1", rd_out, 1);
    chk("rc_r2_accept", up_req_ready, 1);
    step();
    up_drive(1'b0, 1'b0, 32'h0, 32'h0);
    up_rsp_ready = 1'b0;
    #1;
    chk("rc_out_after", rd_out, 1);
    chk("rc_head2", dn_req_addr, 32'h12);
    chk("rc_rsp_empty", up_rsp_valid, 0);
    step();
    dn_rsp_valid = 1'b1; dn_rsp_data = 32'hC;
    step();
    dn_rsp_valid = 1'b0;
    #1;
    chk("rc_rsp_c", up_rsp_data, 32'hC);
    up_rsp_ready = 1'b1;
    step();
    up_rsp_ready = 1'b0;
    #1;
    chk("rc_out0", rd_out, 0);
    chk("rc_idle", idle, 1);

    // mixed traffic with credits exhausted, then response overflow
    up_drive(1'b1, 1'b0, 32'h20, 32'h0);
    step();
    up_drive(1'b1, 1'b0, 32'h21, 32'h0);
    step();
    up_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dn_rsp_valid = 1'b1; dn_rsp_data = 32'h55;
    step();
    dn_rsp_data = 32'h66;
    step();
    dn_rsp_valid = 1'b0;
    up_drive(1'b1, 1'b1, 32'h3C0, 32'h5);
    #1;
    chk("mx_out2", rd_out, 2);
    chk("mx_w0_ready", up_req_ready, 1);
    step();
    up_drive(1'b1, 1'b0, 32'h3C1, 32'h0);
    #1;
    chk("mx_r_held", up_req_ready, 0);
    chk("mx_head_w0", dn_req_addr, 32'h3C0);
    chk("mx_head_w0_data", dn_req_data, 32'h5);
    chk("mx_head_w0_wr", dn_req_write, 1);
    step();
    up_req_write = 1'b1;
    #1; chk("mx_ready_comb_w", up_req_ready, 1);
    up_req_write = 1'b0;
    #1; chk("mx_ready_comb_r", up_req_ready, 0);
    up_rsp_ready = 1'b1;
    step();
    up_rsp_ready = 1'b0;
    #1;
    chk("mx_out1", rd_out, 1);
    chk("mx_r_accept", up_req_ready, 1);
    step();
    up_drive(1'b1, 1'b1, 32'h3C2, 32'h7);
    #1;
    chk("mx_out2b", rd_out, 2);
    chk("mx_w1_ready", up_req_ready, 1);
    chk("mx_head_r", dn_req_addr, 32'h3C1);
    chk("mx_head_r_wr", dn_req_write, 0);
    step();
    up_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dn_rsp_valid = 1'b1; dn_rsp_data = 32'h77;
    #1;
    chk("mx_head_w1", dn_req_addr, 32'h3C2);
    chk("mx_head_w1_data", dn_req_data, 32'h7);
    chk("mx_rsp_room", dn_rsp_ready, 1);
    step();
    dn_rsp_data = 32'hEE;
    #1;
    chk("ov_full", dn_rsp_ready, 0);
    chk("ov_err_before", err, 0);
    step();
    dn_rsp_valid = 1'b0;
    #1;
    chk("ov_err_set", err, 1);
    chk("ov_head_66", up_rsp_data, 32'h66);
    up_rsp_ready = 1'b1;
    step();
    #1;
    chk("ov_head_77", up_rsp_data, 32'h77);
    chk("ov_err_sticky", err, 1);
    step();
    up_rsp_ready = 1'b0;
    #1;
    chk("ov_dropped", up_rsp_valid, 0);
    chk("ov_out0", rd_out, 0);
    chk("ov_err_sticky2", err, 1);
    chk("ov_idle", idle, 1);

    // reset with traffic pending
    dn_req_ready = 1'b0;
    up_drive(1'b1, 1'b0, 32'h40, 32'h0);
    step();
    up_drive(1'b1, 1'b1, 32'h41, 32'h9);
    step();
    up_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dn_rsp_valid = 1'b1; dn_rsp_data = 32'h99;
    step();
    dn_rsp_valid = 1'b0;
    #1;
    chk("rm_pending", dn_req_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_dn_valid", dn_req_valid, 0);
    chk("rm_rsp_valid", up_rsp_valid, 0);
    chk("rm_idle", idle, 1);
    chk("rm_err", err, 0);
    chk("rm_out", rd_out, 0);
    chk("rm_dn_addr", dn_req_addr, 0);
    step();
    rst_n = 1'b1;
    up_rsp_ready = 1'b1;
    dn_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rm_no_stale_rsp", up_rsp_valid, 0);
      chk("rm_no_stale_req", dn_req_valid, 0);
      step();
    end

    // pointer wrap: 20 write/read pairs with random stalls
    u = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (u < 40) begin
        if (u % 2 == 0) up_drive(1'b1, 1'b1, 32'h200 + 32'(u / 2), 32'h1000 + 32'(u));
        else up_drive(1'b1, 1'b0, 32'h300 + 32'(u / 2), 32'h0);
      end else up_drive(1'b0, 1'b0, 32'h0, 32'h0);
      dn_req_ready = ($urandom_range(0, 3) != 0);
      up_rsp_ready = ($urandom_range(0, 3) != 0);
      dn_rsp_valid = (pend.size() > 0) && dn_rsp_ready;
      dn_rsp_data  = (pend.size() > 0) ? pend[0] : 32'h0;
      #1;
      if (up_req_valid && up_req_ready) begin
        exp_req.push_back({up_req_write, up_req_addr, up_req_data});
        if (!up_req_write) exp_rsp.push_back(up_req_addr ^ 32'h5A5A0000);
        u++;
      end
      if (dn_req_valid && dn_req_ready) begin
        if (exp_req.size() == 0) chk("wr_req_extra", dn_req_valid, 0);
        else begin
          e = exp_req.pop_front();
          chk("wr_req_write", dn_req_write, e[64]);
          chk("wr_req_addr", dn_req_addr, e[63:32]);
          chk("wr_req_data", dn_req_data, e[31:0]);
          if (!dn_req_write) pend.push_back(dn_req_addr ^ 32'h5A5A0000);
        end
      end
      if (dn_rsp_valid && dn_rsp_ready) r = pend.pop_front();
      if (up_rsp_valid && up_rsp_ready) begin
        if (exp_rsp.size() == 0) chk("wr_rsp_extra", up_rsp_valid, 0);
        else begin
          r = exp_rsp.pop_front();
          chk("wr_rsp_data", up_rsp_data, r);
        end
      end
      step();
      done = (u == 40) && (exp_req.size() == 0) && (exp_rsp.size() == 0) && (pend.size() == 0);
    end
    chk("wr_completed", done, 1);
    up_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dn_rsp_valid = 1'b0;
    #1;
    chk("wr_idle_end", idle, 1);
    chk("wr_out_end", rd_out, 0);
    chk("wr_err_end", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/snax_csr_req_buffer.md
# snax_csr_req_buffer

Decoupling stage between the SNAX interface translator's simplified CSR port and the streamer's CSR port. Buffers CSR requests in an in-order request FIFO and read responses in an in-order response FIFO. Read admission is credit-based, so a read response is never dropped, and a short CSR stall in the streamer does not back-pressure the core's accelerator request channel. Exposes `idle_o` for barrier generation.

## Interface

Parameters:
- `DataWidth`, 32, CSR data width.
- `AddrWidth`, 32, CSR address width.
- `ReqDepth`, 4, request FIFO entries (≥2).
- `RspDepth`, 2, response FIFO entries and read-credit limit (≥1).

Ports:
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `up_req_data_i`  in  DataWidth  write data from translator.
- `up_req_addr_i`  in  AddrWidth  CSR address.
- `up_req_write_i`  in  1  1 = write, 0 = read.
- `up_req_valid_i`  in  1  request valid.
- `up_req_ready_o`  out  1  request accepted.
- `up_rsp_data_o`  out  DataWidth  read data to translator.
- `up_rsp_valid_o`  out  1  response valid.
- `up_rsp_ready_i`  in  1  translator accepts response.
- `dn_req_data_o`, `dn_req_addr_o`, `dn_req_write_o`  out  DataWidth / AddrWidth / 1  head request to streamer.
- `dn_req_valid_o`  out  1  head valid.
- `dn_req_ready_i`  in  1  streamer accepts.
- `dn_rsp_data_i`  in  DataWidth  read data from streamer.
- `dn_rsp_valid_i`  in  1  response valid.
- `dn_rsp_ready_o`  out  1  response FIFO not full.
- `rd_outstanding_o`  out  $clog2(RspDepth+1)  reads accepted upstream, response not yet delivered.
- `idle_o`  out  1  request FIFO empty and `rd_outstanding_o` == 0.
- `err_o`  out  1  sticky: downstream response arrived with response FIFO full.

## Operation

Request FIFO:
- Circular buffer with read/write pointers; pointers wrap at `ReqDepth-1 → 0`; count width `$clog2(ReqDepth+1)`.
- Push on `up_req_valid_i & up_req_ready_o`. Pop on `dn_req_valid_o & dn_req_ready_i`.
- `dn_req_valid_o` = count != 0; `dn_req_*` driven from the head entry.

Upstream request admission:
- `up_req_ready_o` = (count < ReqDepth) & (`up_req_write_i` | `rd_outstanding_o` < RspDepth).
- Writes ignore credits; reads need one credit.
- Ready depends combinationally on `up_req_write_i`.

Read-credit counter (`rd_outstanding_o`):
- +1 on an accepted upstream read.
- −1 on `up_rsp_valid_o & up_rsp_ready_i`.
- Both in the same cycle: unchanged.
- Never exceeds `RspDepth`.

Response FIFO:
- Same structure as the request FIFO, depth `RspDepth`.
- Push on `dn_rsp_valid_i & dn_rsp_ready_o`; `dn_rsp_ready_o` = not full.
- `up_rsp_valid_o` = not empty; `up_rsp_data_o` = head entry.

Ordering and error handling:
- Strictly in order on both paths.
- Writes produce no response.
- `dn_rsp_valid_i` while the response FIFO is full: data dropped, `err_o` set until reset.

Reset (asynchronous, `rst_ni` low):
- All pointers, counts and credits cleared; storage cleared to 0.
- Outputs: `up_req_ready_o` = 1; all valids = 0; all data/addr/write outputs = 0; `dn_rsp_ready_o` = 1; `rd_outstanding_o` = 0; `idle_o` = 1; `err_o` = 0.
- Reset mid-transaction discards all buffered requests and responses; no response is emitted afterwards for pre-reset reads.

## Timing

- Request latency: accepted at edge N → `dn_req_valid_o` high from cycle N+1. No combinational fall-through.
- Response latency: accepted at edge N → `up_rsp_valid_o` from N+1.
- Throughput: one push and one pop per FIFO per cycle.
- Simultaneous push/pop when not full and not empty: count unchanged.
- Full request FIFO with a pop in the same cycle: `up_req_ready_o` stays 0. Ready is derived from registered count only; no bypass.
- Empty FIFO with a push: the entry is not poppable until the next cycle.
- `dn_req_*` and `up_rsp_*` hold stable while valid and not ready.
- `idle_o` and `rd_outstanding_o` are registered-state derived. `idle_o` falls the cycle after the first accepted request.

## Test plan

- Reset with traffic pending: after `rst_ni` pulses low mid-burst → all valids 0, `idle_o` = 1, `err_o` = 0, no stale response appears.
- Write burst of 6 writes to addresses 0x3C0..0x3C5 with `dn_req_ready_i` = 0 → exactly 4 accepted (`ReqDepth` = 4) and `up_req_ready_o` low. Release ready → the streamer sees 0x3C0..0x3C5 in order, one per cycle; no upstream response.
- Read credit: issue 3 reads with `up_rsp_ready_i` = 0 and the streamer answering 0xA, 0xB → third read stalls with `rd_outstanding_o` = 2. Release → 0xA, 0xB in order, then third read accepted.
- Mixed: W(0x3C0, 5), R(0x3C1), W(0x3C2, 7) with `rd_outstanding_o` = `RspDepth` → writes still accepted, read held until a credit frees.
- Pointer wrap: 20 back-to-back write-read pairs with random ready stalls → scoreboard exact in-order match, `idle_o` = 1 at end.
- Spurious `dn_rsp_valid_i` with the response FIFO full → `err_o` = 1 next cycle and stays 1, FIFO content unchanged.
